// File: rtl/jtpang_obj_linebuf_pkg.sv
// Shared constants for the object line buffer: the transparent pen and the read-sequencer phases.
package jtpang_obj_linebuf_pkg;

   localparam int         LB_AW          = 9;
   localparam int         LB_DW          = 8;
   localparam logic [3:0] OBJ_BLANK      = 4'hF;
   localparam logic [8:0] LB_FLIP_OFFSET = 9'h180;

   typedef enum logic {
      RD_IDLE,
      RD_ERASE
   } rd_phase_e;

   function automatic logic pen_is_blank(input logic [3:0] pen, input logic [3:0] blank);
      return pen == blank;
   endfunction

endpackage

// File: rtl/jtpang_obj_linebuf_if.sv
// Drawer-side write bus plus video-side read bus of the object line buffer.
interface jtpang_obj_linebuf_if #(
   parameter int AW = 9,
   parameter int DW = 8
);
   logic          pxl_cen;
   logic          hs;
   logic          flip;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] wr_addr;
   logic          we;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          init;

   modport master (
      output pxl_cen, hs, flip, wr_data, wr_addr, we, rd_addr,
      input  rd_data, init
   );

   modport slave (
      input  pxl_cen, hs, flip, wr_data, wr_addr, we, rd_addr,
      output rd_data, init
   );
endinterface

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM, read-before-write on each port, one clock domain.
module jtframe_dual_ram #(
   parameter int dw = 8,
   parameter int aw = 10
) (
   input  logic          clk,
   input  logic [dw-1:0] data0,
   input  logic [aw-1:0] addr0,
   input  logic          we0,
   output logic [dw-1:0] q0,
   input  logic [dw-1:0] data1,
   input  logic [aw-1:0] addr1,
   input  logic          we1,
   output logic [dw-1:0] q1
);
   logic [dw-1:0] mem [2**aw];

   always_ff @(posedge clk) begin
      q0 <= mem[addr0];
      q1 <= mem[addr1];
      if (we0) mem[addr0] <= data0;
      if (we1) mem[addr1] <= data1;
   end
endmodule

// File: rtl/jtpang_obj_linebuf.sv
// Double-buffered object line buffer: the drawer fills one bank while the video side
// reads the other, erasing each pixel right after it is shown.
module jtpang_obj_linebuf
   import jtpang_obj_linebuf_pkg::*;
#(
   parameter int            AW          = LB_AW,
   parameter int            DW          = LB_DW,
   parameter logic [3:0]    BLANK       = OBJ_BLANK,
   parameter logic [AW-1:0] FLIP_OFFSET = AW'(LB_FLIP_OFFSET)
) (
   input  logic                 clk,
   input  logic                 rst,
   jtpang_obj_linebuf_if.slave  bus
);
   localparam logic [DW-1:0] BLANK_PXL = {{(DW-4){1'b1}}, BLANK};

   logic          bank;
   logic          hs_l;
   logic          init;
   logic [AW-1:0] clr_cnt;
   rd_phase_e     phase, phase_nxt;
   logic          erase_we;
   logic [AW-1:0] ra;
   logic [AW-1:0] er_addr;
   logic          er_bank;
   logic [AW-1:0] rd_port_addr;
   logic [AW-1:0] wr_port_addr;
   logic [DW-1:0] wr_port_data;
   logic          draw_we;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] q0 [2];
   logic [DW-1:0] q1 [2];
   logic          unused_q0;

   always_ff @(posedge clk) begin
      if (rst) begin
         init    <= 1'b1;
         clr_cnt <= '0;
         bank    <= 1'b0;
         hs_l    <= 1'b0;
         rd_data <= BLANK_PXL;
      end else begin
         hs_l <= bus.hs;
         if (!bus.hs && hs_l) bank <= ~bank;
         if (init) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (&clr_cnt) init <= 1'b0;
         end
         if (erase_we) rd_data <= q1[er_bank];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) phase <= RD_IDLE;
      else     phase <= phase_nxt;
   end

   // The pixel fetch and its erase are split over two clocks around each pxl_cen
   always_comb begin
      phase_nxt = phase;
      erase_we  = 1'b0;
      case (phase)
         RD_IDLE:  if (bus.pxl_cen && !init) phase_nxt = RD_ERASE;
         RD_ERASE: begin
            erase_we  = 1'b1;
            phase_nxt = RD_IDLE;
         end
      endcase
   end

   // Latching the bank keeps the erase on the bank that was read, even across a swap
   always_ff @(posedge clk) begin
      if (phase == RD_IDLE && bus.pxl_cen) begin
         er_addr <= ra;
         er_bank <= ~bank;
      end
   end

   assign ra           = bus.flip ? FLIP_OFFSET - bus.rd_addr : bus.rd_addr;
   assign rd_port_addr = erase_we ? er_addr : ra;
   assign wr_port_addr = init ? clr_cnt : bus.wr_addr;
   assign wr_port_data = init ? BLANK_PXL : bus.wr_data;
   assign draw_we      = bus.we && !init && !pen_is_blank(bus.wr_data[3:0], BLANK);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic BID = (b == 1);
      jtframe_dual_ram #(.dw(DW), .aw(AW)) u_ram (
         .clk   (clk),
         .data0 (wr_port_data),
         .addr0 (wr_port_addr),
         .we0   (init | (draw_we && bank == BID)),
         .q0    (q0[b]),
         .data1 (BLANK_PXL),
         .addr1 (rd_port_addr),
         .we1   (erase_we && er_bank == BID),
         .q1    (q1[b])
      );
   end

   assign unused_q0   = ^{q0[0], q0[1]};
   assign bus.rd_data = rd_data;
   assign bus.init    = init;
endmodule
